// File: rtl/io_port_if.sv
// Device-side pin bundle of the I/O port controller: output port with
// strobe/ack handshake and input port with valid/ready handshake.
interface io_port_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] port_out;
  logic                  port_out_strobe;
  logic                  port_out_ack;
  logic [DATA_WIDTH-1:0] port_in;
  logic                  port_in_valid;
  logic                  port_in_ready;

  modport master (
    output port_out,
    output port_out_strobe,
    output port_in_ready,
    input  port_out_ack,
    input  port_in,
    input  port_in_valid
  );

  modport slave (
    input  port_out,
    input  port_out_strobe,
    input  port_in_ready,
    output port_out_ack,
    output port_in,
    output port_in_valid
  );
endinterface

// File: rtl/io_port_controller.sv
// Sequences IN/OUT instructions onto the external port pins, stalling the
// pipeline for each transaction and bounding every wait with a timeout.
module io_port_controller #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_in_req,
  input  logic                  i_out_req,
  input  logic [DATA_WIDTH-1:0] i_out_data,
  output logic [DATA_WIDTH-1:0] o_in_data,
  output logic                  o_in_valid,
  output logic                  o_stall,
  output logic                  o_timeout,
  io_port_if.master             port
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OUT_WAIT = 2'd1,
    ST_IN_WAIT  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  pend_in_q, pend_in_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] port_out_q, port_out_d;
  logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
  logic                  in_valid_q, in_valid_d;
  logic                  timeout_q, timeout_d;
  logic                  cnt_last_s;

  assign cnt_last_s = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    pend_in_d  = pend_in_q;
    cnt_d      = cnt_q;
    port_out_d = port_out_q;
    in_data_d  = in_data_q;
    in_valid_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_out_req) begin
          port_out_d = i_out_data;
          pend_in_d  = i_in_req;
          cnt_d      = '0;
          state_d    = ST_OUT_WAIT;
        end else if (i_in_req) begin
          cnt_d   = '0;
          state_d = ST_IN_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // An ack on the last allowed cycle still counts as a normal completion.
      ST_OUT_WAIT: begin
        if (port.port_out_ack || cnt_last_s) begin
          timeout_d = ~port.port_out_ack;
          cnt_d     = '0;
          state_d   = pend_in_q ? ST_IN_WAIT : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IN_WAIT: begin
        if (port.port_in_valid) begin
          in_data_d  = port.port_in;
          in_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else if (cnt_last_s) begin
          in_data_d  = '0;
          in_valid_d = 1'b1;
          timeout_d  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Requests are ignored here so the departing instruction is not re-run.
      ST_DONE: begin
        pend_in_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      pend_in_q  <= 1'b0;
      cnt_q      <= '0;
      port_out_q <= '0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_in_q  <= pend_in_d;
      cnt_q      <= cnt_d;
      port_out_q <= port_out_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_stall = ~i_reset &
                   ((state_q == ST_OUT_WAIT) || (state_q == ST_IN_WAIT) ||
                    ((state_q == ST_IDLE) && (i_in_req || i_out_req)));

  assign o_in_data            = in_data_q;
  assign o_in_valid           = in_valid_q;
  assign o_timeout            = timeout_q;
  assign port.port_out        = port_out_q;
  assign port.port_out_strobe = (state_q == ST_OUT_WAIT);
  assign port.port_in_ready   = (state_q == ST_IN_WAIT);

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller with TIMEOUT_CYCLES=4.
module tb_io_port_controller;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_in_req;
  logic        i_out_req;
  logic [15:0] i_out_data;
  logic [15:0] o_in_data;
  logic        o_in_valid;
  logic        o_stall;
  logic        o_timeout;
  int          checks = 0;
  int          errors = 0;

  io_port_if #(.DATA_WIDTH(16)) io ();

  io_port_controller #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_in_req   (i_in_req),
    .i_out_req  (i_out_req),
    .i_out_data (i_out_data),
    .o_in_data  (o_in_data),
    .o_in_valid (o_in_valid),
    .o_stall    (o_stall),
    .o_timeout  (o_timeout),
    .port       (io.master)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_in_req = 1'b0; i_out_req = 1'b0; i_out_data = 16'h0000;
    io.port_out_ack = 1'b0; io.port_in = 16'h0000; io.port_in_valid = 1'b0;
    tick(); tick();
    check("rst_port_out", {16'h0000, io.port_out}, 32'h0);
    check("rst_in_data", {16'h0000, o_in_data}, 32'h0);
    check("rst_bits", {27'd0, o_in_valid, o_stall, o_timeout, io.port_out_strobe, io.port_in_ready}, 32'h0);
    i_reset = 1'b0;
    tick();

    // OUT, fast device
    i_out_req = 1'b1; i_out_data = 16'h00F0; #1;
    check("out1_stall_idle", {31'd0, o_stall}, 32'd1);
    tick();
    io.port_out_ack = 1'b1; #1;
    check("out1_strobe", {31'd0, io.port_out_strobe}, 32'd1);
    check("out1_stall_wait", {31'd0, o_stall}, 32'd1);
    check("out1_port_out", {16'h0000, io.port_out}, 32'h00F0);
    tick();
    io.port_out_ack = 1'b0; #1;
    check("out1_done", {29'd0, o_stall, io.port_out_strobe, o_timeout}, 32'd0);
    i_out_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("out1_hold", {16'h0000, io.port_out}, 32'h00F0);

    // IN, slow device: valid on the 4th IN_WAIT cycle
    i_in_req = 1'b1; io.port_in = 16'hBEEF; #1;
    check("in1_stall_idle", {31'd0, o_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) io.port_in_valid = 1'b1;
      #1;
      check("in1_wait", {30'd0, o_stall, io.port_in_ready}, 32'd3);
    end
    tick();
    io.port_in_valid = 1'b0; #1;
    check("in1_done_stall", {31'd0, o_stall}, 32'd0);
    check("in1_valid", {30'd0, o_in_valid, o_timeout}, 32'd2);
    check("in1_data", {16'h0000, o_in_data}, 32'h0000BEEF);
    i_in_req = 1'b0;
    tick();
    check("in1_single_pulse", {31'd0, o_in_valid}, 32'd0);

    // OUT timeout: exactly 4 OUT_WAIT cycles
    i_out_req = 1'b1; i_out_data = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("out_to_strobe", {31'd0, io.port_out_strobe}, 32'd1);
    end
    tick();
    check("out_to_done", {29'd0, o_timeout, io.port_out_strobe, o_in_valid}, 32'd4);
    check("out_to_hold", {16'h0000, io.port_out}, 32'h0000A5A5);
    i_out_req = 1'b0;
    tick();
    check("out_to_pulse_end", {31'd0, o_timeout}, 32'd0);

    // IN timeout
    i_in_req = 1'b1; io.port_in = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("in_to_ready", {31'd0, io.port_in_ready}, 32'd1);
    end
    tick();
    check("in_to_done", {30'd0, o_timeout, o_in_valid}, 32'd3);
    check("in_to_data", {16'h0000, o_in_data}, 32'h0);
    i_in_req = 1'b0;
    tick();

    // ack on the final allowed OUT_WAIT cycle
    i_out_req = 1'b1; i_out_data = 16'h0C0C;
    tick(); tick(); tick(); tick();
    io.port_out_ack = 1'b1;
    tick();
    io.port_out_ack = 1'b0; i_out_req = 1'b0; #1;
    check("bnd_done", {30'd0, o_timeout, o_stall}, 32'd0);
    check("bnd_port_out", {16'h0000, io.port_out}, 32'h00000C0C);
    tick();

    // simultaneous OUT+IN; early valid must be ignored during OUT_WAIT
    i_out_req = 1'b1; i_in_req = 1'b1; i_out_data = 16'h1234;
    io.port_in = 16'h5678; io.port_in_valid = 1'b1;
    tick();
    io.port_out_ack = 1'b1; #1;
    check("sim_ow", {30'd0, io.port_out_strobe, io.port_in_ready}, 32'd2);
    check("sim_ow_port_out", {16'h0000, io.port_out}, 32'h00001234);
    tick();
    io.port_out_ack = 1'b0; #1;
    check("sim_iw", {29'd0, o_stall, io.port_out_strobe, io.port_in_ready}, 32'd5);
    check("sim_iw_data_untouched", {16'h0000, o_in_data}, 32'h0);
    tick();
    io.port_in_valid = 1'b0; i_out_req = 1'b0; i_in_req = 1'b0; #1;
    check("sim_done", {29'd0, o_in_valid, o_timeout, o_stall}, 32'd4);
    check("sim_in_data", {16'h0000, o_in_data}, 32'h00005678);
    check("sim_port_out", {16'h0000, io.port_out}, 32'h00001234);
    tick();
    check("sim_single_pulse", {31'd0, o_in_valid}, 32'd0);

    // OUT timeout followed by IN: pulse in first IN_WAIT cycle
    i_out_req = 1'b1; i_in_req = 1'b1; i_out_data = 16'h7777; io.port_in = 16'h2222;
    tick(); tick(); tick(); tick();
    tick();
    io.port_in_valid = 1'b1; #1;
    check("oto_iw", {30'd0, o_timeout, io.port_in_ready}, 32'd3);
    tick();
    io.port_in_valid = 1'b0; i_out_req = 1'b0; i_in_req = 1'b0; #1;
    check("oto_done", {30'd0, o_timeout, o_in_valid}, 32'd1);
    check("oto_data", {16'h0000, o_in_data}, 32'h00002222);
    tick();

    // request held through DONE is not serviced twice
    i_out_req = 1'b1; i_out_data = 16'h4321;
    tick();
    io.port_out_ack = 1'b1;
    tick();
    io.port_out_ack = 1'b0; #1;
    check("hold_done_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check("hold_no_retrigger", {31'd0, io.port_out_strobe}, 32'd0);
    i_out_req = 1'b0; #1;
    check("hold_idle_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check("hold_idle_strobe", {31'd0, io.port_out_strobe}, 32'd0);

    // reset during IN_WAIT
    i_in_req = 1'b1;
    tick(); tick();
    i_reset = 1'b1; i_in_req = 1'b0; io.port_in = 16'h9999; io.port_in_valid = 1'b1;
    tick();
    check("rst_mid_bits", {27'd0, o_in_valid, o_stall, o_timeout, io.port_out_strobe, io.port_in_ready}, 32'h0);
    check("rst_mid_port_out", {16'h0000, io.port_out}, 32'h0);
    check("rst_mid_in_data", {16'h0000, o_in_data}, 32'h0);
    i_reset = 1'b0; io.port_in_valid = 1'b0;
    tick();
    check("rst_after", {30'd0, o_in_valid, io.port_in_ready}, 32'd0);
    check("rst_after_data", {16'h0000, o_in_data}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
